// File: rtl/iob_fifo2axis_pkg.sv
// Shared types for the iob_fifo2axis drain engine.
package iob_fifo2axis_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/iob_fifo2axis_buf.sv
// Two-entry FIFO-ordered skid buffer; entry 0 is always the head.
module iob_fifo2axis_buf #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        occ_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic [1:0]        occ_q, occ_d;

    always_comb begin
        mem_d = mem_q;
        occ_d = occ_q;
        if (pop_i && occ_q != 2'd0) begin
            mem_d[0] = mem_q[1];
            occ_d    = occ_q - 2'd1;
        end
        // Push lands after the pop shift so a simultaneous push/pop keeps order.
        if (push_i && occ_d != 2'd2) begin
            mem_d[occ_d[0]] = push_data_i;
            occ_d           = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            occ_q    <= 2'd0;
        end else if (cke_i) begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[0];

endmodule

// File: rtl/iob_fifo2axis.sv
// Drains a programmed number of words from a 1-cycle-latency FIFO read port onto AXI-Stream.
module iob_fifo2axis
    import iob_fifo2axis_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fifo_r_en_o,
    input  logic [DATA_W-1:0] fifo_r_data_i,
    input  logic              fifo_r_empty_i,
    output logic              axis_tvalid_o,
    output logic [DATA_W-1:0] axis_tdata_o,
    output logic              axis_tlast_o,
    input  logic              axis_tready_i
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   rd_left_q, rd_left_d;
    logic [LEN_W-1:0]   tx_left_q, tx_left_d;
    logic               pend_q;
    logic [1:0]         occ;
    logic [DATA_W-1:0]  head;
    logic               pop;
    logic               space;

    iob_fifo2axis_buf #(
        .DATA_W(DATA_W)
    ) u_buf (
        .clk_i      (clk_i),
        .cke_i      (cke_i),
        .rst_i      (rst_i),
        .push_i     (pend_q),
        .push_data_i(fifo_r_data_i),
        .pop_i      (pop),
        .occ_o      (occ),
        .head_o     (head)
    );

    assign axis_tvalid_o = (occ != 2'd0);
    assign axis_tdata_o  = head;
    assign axis_tlast_o  = axis_tvalid_o && (tx_left_q == LEN_W'(1));
    assign pop           = axis_tvalid_o && axis_tready_i;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);

    // Count the in-flight read against capacity so occ can never exceed 2.
    assign space = (({1'b0, occ} + {2'b00, pend_q}) < 3'd2) || pop;

    always_comb begin
        state_d     = state_q;
        rd_left_d   = rd_left_q;
        tx_left_d   = tx_left_q;
        fifo_r_en_o = cke_i && (state_q == StRun) && (rd_left_q != '0) &&
                      !fifo_r_empty_i && space;

        if (fifo_r_en_o) begin
            rd_left_d = rd_left_q - LEN_W'(1);
        end
        if (pop && tx_left_q != '0) begin
            tx_left_d = tx_left_q - LEN_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    if (len_i != '0) begin
                        state_d   = StRun;
                        rd_left_d = len_i;
                        tx_left_d = len_i;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (fifo_r_en_o && rd_left_q == LEN_W'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && tx_left_q == LEN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            rd_left_q <= '0;
            tx_left_q <= '0;
            pend_q    <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            rd_left_q <= rd_left_d;
            tx_left_q <= tx_left_d;
            pend_q    <= fifo_r_en_o;
        end
    end

endmodule

// File: tb/tb_iob_fifo2axis.sv
// Scoreboard bench for iob_fifo2axis with a behavioural FIFO and randomized stream backpressure.
module tb_iob_fifo2axis;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int NWORDS = 1024;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } beat_t;

    logic              clk = 1'b0;
    logic              cke, rst, en, tready;
    logic [LEN_W-1:0]  len;
    logic              busy, done, r_en, r_empty, tvalid, tlast;
    logic [DATA_W-1:0] r_data, tdata;

    logic [DATA_W-1:0] words [NWORDS];
    int                wr_cnt = 0;
    int                rd_ptr = 0;
    beat_t             exp_q [$];
    int                pass_cnt = 0;
    int                tot_cnt = 0;
    int                ren_total = 0;
    int                hs_cnt = 0;
    int                rdy_mode = 0;
    bit                trickle = 0;

    always #5 clk = ~clk;

    iob_fifo2axis #(
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk_i         (clk),
        .cke_i         (cke),
        .rst_i         (rst),
        .en_i          (en),
        .len_i         (len),
        .busy_o        (busy),
        .done_o        (done),
        .fifo_r_en_o   (r_en),
        .fifo_r_data_i (r_data),
        .fifo_r_empty_i(r_empty),
        .axis_tvalid_o (tvalid),
        .axis_tdata_o  (tdata),
        .axis_tlast_o  (tlast),
        .axis_tready_i (tready)
    );

    // Behavioural FIFO with one-cycle read latency.
    assign r_empty = (rd_ptr >= wr_cnt);
    always @(posedge clk) begin
        if (r_en && rd_ptr < wr_cnt) begin
            r_data <= words[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Monitor: scoreboard pops on every accepted beat, and stalled beats must hold.
    logic              hold_prev = 0;
    logic [DATA_W-1:0] hold_data;
    logic              hold_last;
    always @(negedge clk) begin
        beat_t b;
        if (hold_prev && !rst) begin
            check("stall_valid", tvalid, 1);
            check("stall_data", tdata, hold_data);
            check("stall_last", tlast, hold_last);
        end
        if (!rst && cke) begin
            if (r_en) ren_total++;
            if (tvalid && tready) begin
                hs_cnt++;
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    check("beat_data", tdata, b.d);
                    check("beat_last", tlast, b.l);
                end
            end
        end
        hold_prev = tvalid && (!tready || !cke) && !rst;
        hold_data = tdata;
        hold_last = tlast;
    end

    task automatic step();
        @(posedge clk);
        #1;
        en = 1'b0;
        case (rdy_mode)
            0: tready = 1'b1;
            1: tready = ~tready;
            default: tready = ($urandom_range(0, 3) != 0);
        endcase
        if (trickle && wr_cnt < NWORDS && $urandom_range(0, 2) == 0) wr_cnt++;
    endtask

    // Expected beats are the next l words the FIFO will yield, last flag on the final one.
    task automatic start(input int l);
        beat_t b;
        en  = 1'b1;
        len = LEN_W'(l);
        for (int i = 0; i < l; i++) begin
            b.d = words[(rd_ptr + i) % NWORDS];
            b.l = (i == l - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(input string name, input int l, input int base, input int budget);
        int n = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            step();
            @(negedge clk);
            #1;
            if (done) seen = 1;
            n++;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_reads"}, ren_total - base, l);
        check({name, "_beats_left"}, exp_q.size(), 0);
        step();
        @(negedge clk);
        check({name, "_done_pulse"}, done, 0);
        check({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int base, hs_base, l;
        logic              fz_valid, fz_last, fz_busy;
        logic [DATA_W-1:0] fz_data;
        logic [3:0]        t1;

        for (int i = 0; i < NWORDS; i++) words[i] = $urandom;
        cke = 1; rst = 1; en = 0; len = '0; tready = 0;
        repeat (3) step();
        rst = 0;
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tlast", tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ren", r_en, 0);

        // Cycle-exact latency with four preloaded words.
        wr_cnt += 4; rdy_mode = 0; base = ren_total;
        for (int c = 0; c <= 8; c++) begin
            step();
            if (c == 0) start(4);
            @(negedge clk);
            t1 = 4'(c);
            check($sformatf("t1_ren_c%0d", c), r_en, (t1 >= 1 && t1 <= 4));
            check($sformatf("t1_valid_c%0d", c), tvalid, (t1 >= 3 && t1 <= 6));
            check($sformatf("t1_last_c%0d", c), tlast, (t1 == 6));
            check($sformatf("t1_done_c%0d", c), done, (t1 == 7));
            check($sformatf("t1_busy_c%0d", c), busy, (t1 >= 1 && t1 <= 7));
        end
        check("t1_reads", ren_total - base, 4);
        check("t1_beats_left", exp_q.size(), 0);

        // Alternating backpressure.
        wr_cnt += 8; rdy_mode = 1; tready = 1'b0;
        step(); start(8); base = ren_total;
        wait_done("t2", 8, base, 100);

        // FIFO runs dry mid-transfer, refilled later.
        wr_cnt += 2; rdy_mode = 0;
        step(); start(6); base = ren_total;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 10) wr_cnt += 4;
            @(negedge clk);
            if (c == 8) check("t3_gap_valid", tvalid, 0);
        end
        wait_done("t3", 6, base, 100);

        // Zero-length request.
        step(); start(0); base = ren_total;
        step();
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_ren", r_en, 0);
        check("t4_valid", tvalid, 0);
        step();
        @(negedge clk);
        check("t4_done_pulse", done, 0);
        check("t4_busy", busy, 0);
        check("t4_reads", ren_total - base, 0);

        // Reset after the second handshake, then a fresh 2-word transfer.
        wr_cnt += 8; rdy_mode = 0;
        step(); start(5); hs_base = hs_cnt;
        for (int c = 0; c < 20 && (hs_cnt - hs_base) < 2; c++) begin
            step();
            @(negedge clk);
            #1;
        end
        check("t5_two_beats", hs_cnt - hs_base >= 2, 1);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t5_valid", tvalid, 0);
        check("t5_busy", busy, 0);
        check("t5_last", tlast, 0);
        check("t5_done", done, 0);
        step();
        @(negedge clk);
        check("t5_valid_after", tvalid, 0);
        step(); start(2); base = ren_total;
        wait_done("t5", 2, base, 50);

        // Clock enable held low for three cycles mid-burst.
        wr_cnt += 8; rdy_mode = 0;
        step(); start(8); base = ren_total; hs_base = hs_cnt;
        for (int c = 0; c < 20 && (hs_cnt - hs_base) < 1; c++) begin
            step();
            @(negedge clk);
            #1;
        end
        step(); cke = 1'b0;
        @(negedge clk);
        fz_valid = tvalid; fz_data = tdata; fz_last = tlast; fz_busy = busy;
        check("t6_ren_0", r_en, 0);
        for (int c = 1; c < 3; c++) begin
            step();
            @(negedge clk);
            check("t6_ren", r_en, 0);
            check("t6_valid_frozen", tvalid, fz_valid);
            check("t6_data_frozen", tdata, fz_data);
            check("t6_last_frozen", tlast, fz_last);
            check("t6_busy_frozen", busy, fz_busy);
        end
        step(); cke = 1'b1;
        wait_done("t6", 8, base, 100);

        // Random lengths, random tready, words trickling into the FIFO.
        rdy_mode = 2; trickle = 1;
        for (int k = 0; k < 10; k++) begin
            l = $urandom_range(1, 20);
            if (wr_cnt < NWORDS - 5) wr_cnt += $urandom_range(0, 5);
            step(); start(l); base = ren_total;
            wait_done($sformatf("rnd%0d", k), l, base, 400);
            exp_q.delete();
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit, passed %0d of %0d", pass_cnt, tot_cnt);
        $fatal(1, "timeout");
    end

endmodule
